// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: accepts a, b, bin over a valid/ready handshake,
// resolves one difference bit per cycle LSB first through a full-subtractor
// cell (two half-subtractors plus a borrow register), then presents diff and
// bout over a second valid/ready handshake.
// Optional feature macro: SERIAL_SUB_SATURATE_EN (clamp diff to 0 on final borrow).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               br_q, br_d;
  logic               bout_q, bout_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic               hs1_diff, hs1_borrow;
  logic               d_bit, hs2_borrow, br_next;
  logic               last_bit;

  // Full-subtractor cell on the current LSB of the shifting operand registers
  always_comb begin
    hs1_diff   = a_q[0] ^ b_q[0];
    hs1_borrow = ~a_q[0] & b_q[0];
    d_bit      = hs1_diff ^ br_q;
    hs2_borrow = ~hs1_diff & br_q;
    br_next    = hs1_borrow | hs2_borrow;
    last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    br_d        = br_q;
    bout_d      = bout_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_next;
        diff_d = (diff_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          bout_d      = br_next;
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef SERIAL_SUB_SATURATE_EN
          if (br_next) begin
            diff_d = '0;
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // in_ready tracks rst directly so it drops during reset and rises right after release
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed vectors plus a
// WIDTH=1 instance swept over all operand combinations.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, bin8, bout8, busy8;
  logic [7:0] a8, b8, diff8;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, bin1, bout1, busy1;
  logic [0:0] a1, b1, diff1;

  int n_cmp;
  int n_err;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  int         seen8;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .busy(busy8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: pop and compare each accepted result of the 8-bit instance
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      seen8++;
      if (q8.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut8_unexpected_result: got {bout,diff}=0x%0h expected none", {bout8, diff8});
      end else begin
        chk("dut8_result", 32'({bout8, diff8}), 32'(q8.pop_front()));
      end
    end
  end

  // Monitor: pop and compare each accepted result of the 1-bit instance
  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut1_unexpected_result: got {bout,diff}=0x%0h expected none", {bout1, diff1});
      end else begin
        chk("dut1_result", 32'({bout1, diff1}), 32'(q1.pop_front()));
      end
    end
  end

  task automatic wait_ready8();
    int n;
    n = 0;
    while (!in_ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready8) chk("dut8_ready_timeout", 32'(in_ready8), 32'd1);
  endtask

  // Issue one operation on the 8-bit instance; optionally check latency and pulse width
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input bit push, input logic [8:0] exp, input bit chk_lat);
    int cyc;
    wait_ready8();
    a8 = a; b8 = b; bin8 = bi; in_valid8 = 1'b1;
    if (push) q8.push_back(exp);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    a8 = 8'hC3; b8 = 8'h3C; bin8 = 1'b1;
    if (!chk_lat) return;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid8) break;
    end
    chk("dut8_latency", 32'(cyc), 32'd8);
    if (out_ready8) begin
      @(posedge clk);
      @(negedge clk);
      chk("dut8_valid_one_cycle", 32'(out_valid8), 32'd0);
    end
  endtask

  function automatic logic [8:0] sat8(input logic [8:0] v);
`ifdef SERIAL_SUB_SATURATE_EN
    if (v[8]) return 9'h100;
`endif
    return v;
  endfunction

  // Reference for the 1-bit instance: {bout,diff} = (a-b-bin) mod 4
  function automatic logic [1:0] model1(input int a, input int b, input int bi);
    logic [1:0] v;
    v = 2'((a - b - bi) & 3);
`ifdef SERIAL_SUB_SATURATE_EN
    if (v[1]) v[0] = 1'b0;
`endif
    return v;
  endfunction

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int saw;
    n_cmp = 0; n_err = 0; seen8 = 0;
    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; bin8 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; bin1 = 1'b0;

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 9'h037};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 9'h1FF};
    vecs[2] = '{8'h10, 8'h10, 1'b1, 9'h1FF};
    vecs[3] = '{8'h80, 8'h7F, 1'b1, 9'h000};
    vecs[4] = '{8'hFF, 8'h00, 1'b1, 9'h0FE};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 9'h100};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready8), 32'd0);
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_diff_bout", 32'({bout8, diff8}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready8), 32'd1);

    // Directed vectors with latency and single-cycle valid check
    foreach (vecs[i]) send8(vecs[i].a, vecs[i].b, vecs[i].bi, 1'b1, sat8(vecs[i].exp), 1'b1);

    // Backpressure: hold result in DONE, ignore new operands
    out_ready8 = 1'b0;
    send8(8'h33, 8'h11, 1'b0, 1'b1, 9'h022, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; in_valid8 = 1'b1;
      end else begin
        in_valid8 = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid8), 32'd1);
      chk("bp_result_held", 32'({bout8, diff8}), 32'h022);
      chk("bp_in_ready", 32'(in_ready8), 32'd0);
    end
    in_valid8 = 1'b0;
    saw = seen8;
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_released", 32'(seen8 - saw), 32'd1);
    chk("bp_out_valid_dropped", 32'(out_valid8), 32'd0);
    chk("bp_back_idle", 32'(in_ready8), 32'd1);

    // Reset on the 3rd BUSY cycle discards the operation
    send8(8'h5A, 8'h23, 1'b0, 1'b0, 9'h000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready8), 32'd1);
    chk("midrst_out_valid", 32'(out_valid8), 32'd0);
    chk("midrst_busy", 32'(busy8), 32'd0);
    saw = seen8;
    repeat (15) @(negedge clk);
    chk("midrst_no_result", 32'(seen8 - saw), 32'd0);

    // Recovery after mid-operation reset
    send8(8'h80, 8'h01, 1'b0, 1'b1, 9'h07F, 1'b1);

    // WIDTH=1 exhaustive sweep
    for (int v = 0; v < 8; v++) begin
      n = 0;
      while (!in_ready1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready1) chk("dut1_ready_timeout", 32'(in_ready1), 32'd1);
      a1 = 1'(v >> 2); b1 = 1'(v >> 1); bin1 = 1'(v);
      q1.push_back(model1((v >> 2) & 1, (v >> 1) & 1, v & 1));
      in_valid1 = 1'b1;
      @(posedge clk);
      #1 in_valid1 = 1'b0;
      n = 0;
      while (n < 10) begin
        @(negedge clk);
        n++;
        if (out_valid1) break;
      end
      chk("dut1_latency", 32'(n), 32'd2);
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("dut8_queue_drained", 32'(q8.size()), 32'd0);
    chk("dut1_queue_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
